// File: rtl/uart_tx_sched_pkg.sv
// Shared state encoding, source IDs and widths for the UART TX scheduler.
package uart_tx_sched_pkg;

    localparam int unsigned ByteW  = 8;
    localparam int unsigned NumSrc = 2;
    localparam int unsigned SrcAlu = 0;
    localparam int unsigned SrcRf  = 1;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StWaitHi = 2'd1,
        StWaitLo = 2'd2
    } state_e;

endpackage

// File: rtl/uart_tx_sched_arb.sv
// Two-source grant logic for the UART TX scheduler.
// UART_TX_SCHED_RR_EN selects round-robin; otherwise ALU has fixed priority over RF.
module uart_tx_sched_arb
    import uart_tx_sched_pkg::*;
(
`ifdef UART_TX_SCHED_RR_EN
    input  logic              clk,
    input  logic              rst,
`endif
    input  logic [NumSrc-1:0] req,
    input  logic              grant_en,
    output logic [NumSrc-1:0] grant
);

`ifdef UART_TX_SCHED_RR_EN
    // Source preferred when both request; flips to the other source on every grant.
    logic ptr_q, ptr_d;

    always_comb begin
        grant = '0;
        ptr_d = ptr_q;
        if (grant_en) begin
            if (req[SrcAlu] && (!req[SrcRf] || (ptr_q == 1'(SrcAlu)))) begin
                grant[SrcAlu] = 1'b1;
                ptr_d         = 1'(SrcRf);
            end else if (req[SrcRf]) begin
                grant[SrcRf] = 1'b1;
                ptr_d        = 1'(SrcAlu);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= 1'(SrcAlu);
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    always_comb begin
        grant = '0;
        if (grant_en) begin
            if (req[SrcAlu]) begin
                grant[SrcAlu] = 1'b1;
            end else if (req[SrcRf]) begin
                grant[SrcRf] = 1'b1;
            end
        end
    end
`endif

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one UART transmitter between the ALU (2-byte) and register-file (1-byte) requesters.
// Define UART_TX_SCHED_RR_EN for round-robin arbitration instead of fixed ALU priority.
module uart_tx_scheduler
    import uart_tx_sched_pkg::*;
#(
    parameter int unsigned BUSY_TIMEOUT = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             alu_valid,
    input  logic [15:0]      alu_data,
    output logic             alu_ack,
    input  logic             rf_valid,
    input  logic [ByteW-1:0] rf_data,
    output logic             rf_ack,
    input  logic             tx_busy,
    output logic             tx_valid,
    output logic [ByteW-1:0] tx_data,
    output logic             sched_busy,
    output logic             tx_err
);

    localparam int unsigned    WdW    = $clog2(BUSY_TIMEOUT + 1);
    localparam logic [WdW-1:0] WdLast = WdW'(BUSY_TIMEOUT - 1);
    localparam logic [WdW-1:0] WdMax  = WdW'(BUSY_TIMEOUT);

    state_e               state_q, state_d;
    logic [2*ByteW-1:0]   hold_q, hold_d;
    logic                 byte_sel_q, byte_sel_d;
    logic                 bytes_rem_q, bytes_rem_d;
    logic [WdW-1:0]       wdog_q, wdog_d;
    logic                 alu_ack_q, alu_ack_d;
    logic                 rf_ack_q, rf_ack_d;
    logic                 tx_valid_q, tx_valid_d;
    logic                 tx_err_q, tx_err_d;
    logic                 grant_en;
    logic [NumSrc-1:0]    grant;
    logic [NumSrc-1:0]    req;

    assign req[SrcAlu] = alu_valid;
    assign req[SrcRf]  = rf_valid;
    assign grant_en    = (state_q == StIdle) && !tx_busy;

    uart_tx_sched_arb u_arb (
`ifdef UART_TX_SCHED_RR_EN
        .clk      (clk),
        .rst      (rst),
`endif
        .req      (req),
        .grant_en (grant_en),
        .grant    (grant)
    );

    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        byte_sel_d  = byte_sel_q;
        bytes_rem_d = bytes_rem_q;
        wdog_d      = wdog_q;
        alu_ack_d   = 1'b0;
        rf_ack_d    = 1'b0;
        tx_valid_d  = 1'b0;
        tx_err_d    = 1'b0;
        unique case (state_q)
            StIdle: begin
                wdog_d = '0;
                if (grant[SrcAlu]) begin
                    alu_ack_d   = 1'b1;
                    hold_d      = alu_data;
                    byte_sel_d  = 1'b0;
                    bytes_rem_d = 1'b1;
                    tx_valid_d  = 1'b1;
                    state_d     = StWaitHi;
                end else if (grant[SrcRf]) begin
                    rf_ack_d    = 1'b1;
                    hold_d      = {{ByteW{1'b0}}, rf_data};
                    byte_sel_d  = 1'b0;
                    bytes_rem_d = 1'b0;
                    tx_valid_d  = 1'b1;
                    state_d     = StWaitHi;
                end
            end
            StWaitHi: begin
                if (tx_busy) begin
                    wdog_d  = '0;
                    state_d = StWaitLo;
                end else if (wdog_q == WdLast) begin
                    // Transmitter never took the byte: drop the rest of the frame.
                    tx_err_d    = 1'b1;
                    bytes_rem_d = 1'b0;
                    wdog_d      = WdMax;
                    state_d     = StIdle;
                end else if (wdog_q != WdMax) begin
                    wdog_d = wdog_q + 1'b1;
                end
            end
            StWaitLo: begin
                if (!tx_busy) begin
                    if (bytes_rem_q) begin
                        byte_sel_d  = 1'b1;
                        bytes_rem_d = 1'b0;
                        tx_valid_d  = 1'b1;
                        wdog_d      = '0;
                        state_d     = StWaitHi;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            hold_q      <= '0;
            byte_sel_q  <= 1'b0;
            bytes_rem_q <= 1'b0;
            wdog_q      <= '0;
            alu_ack_q   <= 1'b0;
            rf_ack_q    <= 1'b0;
            tx_valid_q  <= 1'b0;
            tx_err_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            byte_sel_q  <= byte_sel_d;
            bytes_rem_q <= bytes_rem_d;
            wdog_q      <= wdog_d;
            alu_ack_q   <= alu_ack_d;
            rf_ack_q    <= rf_ack_d;
            tx_valid_q  <= tx_valid_d;
            tx_err_q    <= tx_err_d;
        end
    end

    // Byte select only moves on a strobe, so tx_data holds until the next strobe.
    assign tx_data    = byte_sel_q ? hold_q[2*ByteW-1:ByteW] : hold_q[ByteW-1:0];
    assign alu_ack    = alu_ack_q;
    assign rf_ack     = rf_ack_q;
    assign tx_valid   = tx_valid_q;
    assign tx_err     = tx_err_q;
    assign sched_busy = (state_q != StIdle);

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Self-checking bench for uart_tx_scheduler: frame-timeline reference model plus directed pins.
module tb_uart_tx_scheduler;

    localparam int T = 32;
    localparam int N = 8192;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        alu_valid = 1'b0;
    logic [15:0] alu_data = '0;
    logic        rf_valid = 1'b0;
    logic [7:0]  rf_data = '0;
    logic        tx_busy = 1'b0;
    logic        alu_ack, rf_ack, tx_valid, sched_busy, tx_err;
    logic [7:0]  tx_data;

    uart_tx_scheduler #(.BUSY_TIMEOUT(T)) dut (
        .clk        (clk),
        .rst        (rst),
        .alu_valid  (alu_valid),
        .alu_data   (alu_data),
        .alu_ack    (alu_ack),
        .rf_valid   (rf_valid),
        .rf_data    (rf_data),
        .rf_ack     (rf_ack),
        .tx_busy    (tx_busy),
        .tx_valid   (tx_valid),
        .tx_data    (tx_data),
        .sched_busy (sched_busy),
        .tx_err     (tx_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    // Expected per-cycle outputs, filled ahead of time when a frame is granted.
    bit       e_alu_ack[N];
    bit       e_rf_ack[N];
    bit       e_valid[N];
    bit       e_err[N];
    bit       e_sbusy[N];
    bit       busy_sched[N];
    bit [7:0] e_byte[N];
    bit [7:0] e_data_cur = '0;

    int idle_from = 0;
    int delay_mode = 1;   // 0 random, 1 rise after 2 / hold 10, 2 never rises
    bit noise_en = 0;
    bit hold_en = 0;
    bit req_rand = 0;
    int rr_pref = 0;
    int alu_drop_at = -1;
    int rf_drop_at = -1;

    bit          cmd_alu = 0, cmd_rf = 0, cmd_drop = 0;
    logic [15:0] cmd_alu_data;
    logic [7:0]  cmd_rf_data;
    int          cmd_cyc = 0;

    logic [7:0] strobe_log[$];
    int         strobe_cyc[$];
    int         ack_log[$];
    int         last_ack_cyc = 0, last_err_cyc = 0, err_cnt = 0;
    int         exp_order[3];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
        end
    endtask

    task automatic clear_logs();
        strobe_log.delete();
        strobe_cyc.delete();
        ack_log.delete();
        err_cnt = 0;
    endtask

    task automatic draw(output int d1, output int h);
        if (delay_mode == 1) begin
            d1 = 2;
            h  = 10;
        end else if (delay_mode == 2) begin
            d1 = 0;
            h  = 0;
        end else begin
            if ($urandom_range(0, 9) == 0) d1 = 0;
            else if ($urandom_range(0, 3) == 0) d1 = int'($urandom_range(1, T - 1));
            else d1 = int'($urandom_range(1, 4));
            h = int'($urandom_range(1, 12));
        end
    endtask

    // Lay out a whole frame granted in idle cycle g: strobes, busy window, error, busy span.
    task automatic plan_frame(input int g, input int src, input logic [15:0] data);
        int s, d1, h, r, endc, nb;
        s    = g + 1;
        endc = s;
        nb   = (src == 0) ? 2 : 1;
        if (src == 0) e_alu_ack[s] = 1'b1;
        else e_rf_ack[s] = 1'b1;
        for (int k = 0; k < nb; k++) begin
            e_valid[s] = 1'b1;
            e_byte[s]  = (k == 0) ? data[7:0] : data[15:8];
            draw(d1, h);
            if (d1 == 0) begin
                e_err[s + T] = 1'b1;
                endc = s + T;
                break;
            end
            r = s + d1;
            for (int j = 0; j < h; j++) busy_sched[r + j] = 1'b1;
            if (k == nb - 1) endc = r + h + 1;
            else s = r + h + 1;
        end
        for (int c = g + 1; c < endc; c++) e_sbusy[c] = 1'b1;
        idle_from = endc;
    endtask

    task automatic compare();
        if (cyc >= N - 200) begin
            $display("FAIL cycle_budget cyc=%0d exceeded limit %0d", cyc, N - 200);
            $fatal(1, "cycle budget exhausted");
        end
        if (e_valid[cyc]) e_data_cur = e_byte[cyc];
        chk("alu_ack", 32'(alu_ack), 32'(e_alu_ack[cyc]));
        chk("rf_ack", 32'(rf_ack), 32'(e_rf_ack[cyc]));
        chk("tx_valid", 32'(tx_valid), 32'(e_valid[cyc]));
        chk("tx_data", 32'(tx_data), 32'(e_data_cur));
        chk("tx_err", 32'(tx_err), 32'(e_err[cyc]));
        chk("sched_busy", 32'(sched_busy), 32'(e_sbusy[cyc]));
        if (tx_valid === 1'b1) begin
            strobe_log.push_back(tx_data);
            strobe_cyc.push_back(cyc);
        end
        if (alu_ack === 1'b1) begin
            ack_log.push_back(0);
            last_ack_cyc = cyc;
        end
        if (rf_ack === 1'b1) begin
            ack_log.push_back(1);
            last_ack_cyc = cyc;
        end
        if (tx_err === 1'b1) begin
            err_cnt++;
            last_err_cyc = cyc;
        end
    endtask

    task automatic apply_cmds();
        if (cmd_alu) begin
            alu_valid = 1'b1;
            alu_data  = cmd_alu_data;
            cmd_cyc   = cyc;
        end
        if (cmd_rf) begin
            rf_valid = 1'b1;
            rf_data  = cmd_rf_data;
            cmd_cyc  = cyc;
        end
        if (cmd_drop) begin
            alu_valid = 1'b0;
            rf_valid  = 1'b0;
        end
        cmd_alu  = 0;
        cmd_rf   = 0;
        cmd_drop = 0;
    endtask

    // Drive this cycle's inputs, then decide whether the scheduler grants in this cycle.
    task automatic step();
        int src;
        if (cyc == alu_drop_at) begin
            alu_drop_at = -1;
            if (!hold_en) alu_valid = 1'b0;
        end
        if (cyc == rf_drop_at) begin
            rf_drop_at = -1;
            if (!hold_en) rf_valid = 1'b0;
        end
        if (req_rand) begin
            if (!alu_valid && $urandom_range(0, 7) == 0) begin
                alu_valid = 1'b1;
                alu_data  = 16'($urandom);
            end else if (alu_valid && alu_drop_at < 0 && $urandom_range(0, 59) == 0) begin
                alu_valid = 1'b0;
            end
            if (!rf_valid && $urandom_range(0, 7) == 0) begin
                rf_valid = 1'b1;
                rf_data  = 8'($urandom);
            end else if (rf_valid && rf_drop_at < 0 && $urandom_range(0, 59) == 0) begin
                rf_valid = 1'b0;
            end
        end
        if (noise_en && cyc >= idle_from && !busy_sched[cyc] && $urandom_range(0, 24) == 0) begin
            int len = int'($urandom_range(1, 5));
            for (int j = 0; j < len; j++) busy_sched[cyc + j] = 1'b1;
        end
        tx_busy = busy_sched[cyc];
        if (!rst && cyc >= idle_from && !tx_busy && (alu_valid || rf_valid)) begin
`ifdef UART_TX_SCHED_RR_EN
            if (alu_valid && rf_valid) src = rr_pref;
            else src = alu_valid ? 0 : 1;
            rr_pref = 1 - src;
`else
            src = alu_valid ? 0 : 1;
`endif
            if (src == 0) begin
                plan_frame(cyc, 0, alu_data);
                alu_drop_at = cyc + 1;
            end else begin
                plan_frame(cyc, 1, {8'h00, rf_data});
                rf_drop_at = cyc + 1;
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
        compare();
        apply_cmds();
        step();
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_alu_ack"}, 32'(alu_ack), 32'd0);
        chk({tag, "_rf_ack"}, 32'(rf_ack), 32'd0);
        chk({tag, "_tx_valid"}, 32'(tx_valid), 32'd0);
        chk({tag, "_tx_data"}, 32'(tx_data), 32'd0);
        chk({tag, "_tx_err"}, 32'(tx_err), 32'd0);
        chk({tag, "_sched_busy"}, 32'(sched_busy), 32'd0);
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        tx_busy   = 1'b0;
        alu_valid = 1'b0;
        rf_valid  = 1'b0;
        for (int c = cyc; c < cyc + 300 && c < N; c++) begin
            e_alu_ack[c]  = 0;
            e_rf_ack[c]   = 0;
            e_valid[c]    = 0;
            e_err[c]      = 0;
            e_sbusy[c]    = 0;
            e_byte[c]     = '0;
            busy_sched[c] = 0;
        end
        idle_from   = cyc + 1;
        alu_drop_at = -1;
        rf_drop_at  = -1;
        rr_pref     = 0;
        e_data_cur  = '0;
        #1;
        check_outputs_zero("reset");
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic run_until_idle(input int limit);
        int n = 0;
        while (!(cyc >= idle_from + 2 && !alu_valid && !rf_valid) && n < limit) begin
            tick();
            n++;
        end
        total++;
        if (!(cyc >= idle_from + 2 && !alu_valid && !rf_valid)) begin
            bad++;
            $display("FAIL idle_wait cyc=%0d got=busy want=idle within %0d cycles", cyc, limit);
        end
    endtask

    initial begin
`ifdef UART_TX_SCHED_RR_EN
        exp_order = '{0, 1, 0};
`else
        exp_order = '{0, 0, 0};
`endif
        repeat (3) tick();
        #1;
        check_outputs_zero("init");
        rst = 1'b0;
        tick();

        // Both requesters held valid across three frames from a fresh reset.
        clear_logs();
        delay_mode = 1;
        hold_en = 1;
        cmd_alu = 1; cmd_alu_data = 16'h1234;
        cmd_rf = 1; cmd_rf_data = 8'h56;
        begin
            int n = 0;
            while (ack_log.size() < 3 && n < 400) begin
                tick();
                n++;
            end
        end
        chk("held_ack_count", 32'(ack_log.size()), 32'd3);
        for (int i = 0; i < 3 && i < ack_log.size(); i++)
            chk("held_order", 32'(ack_log[i]), 32'(exp_order[i]));
        cmd_drop = 1;
        hold_en = 0;
        run_until_idle(300);

        // Simultaneous single requests: ALU frame completes before the RF byte.
        do_reset();
        clear_logs();
        cmd_alu = 1; cmd_alu_data = 16'hBEEF;
        cmd_rf = 1; cmd_rf_data = 8'h42;
        run_until_idle(300);
        chk("sim_acks", 32'(ack_log.size()), 32'd2);
        chk("sim_strobes", 32'(strobe_log.size()), 32'd3);
        if (ack_log.size() == 2) begin
            chk("sim_first", 32'(ack_log[0]), 32'd0);
            chk("sim_second", 32'(ack_log[1]), 32'd1);
        end
        if (strobe_log.size() == 3) begin
            chk("sim_b0", 32'(strobe_log[0]), 32'h00EF);
            chk("sim_b1", 32'(strobe_log[1]), 32'h00BE);
            chk("sim_b2", 32'(strobe_log[2]), 32'h0042);
        end

        // ALU-only frame with busy rising 2 cycles after each strobe and held 10.
        clear_logs();
        cmd_alu = 1; cmd_alu_data = 16'hA55A;
        tick();
        run_until_idle(200);
        chk("alu_latency", 32'(last_ack_cyc - cmd_cyc), 32'd1);
        chk("alu_strobes", 32'(strobe_log.size()), 32'd2);
        if (strobe_log.size() == 2) begin
            chk("alu_lsb", 32'(strobe_log[0]), 32'h005A);
            chk("alu_msb", 32'(strobe_log[1]), 32'h00A5);
            chk("alu_gap", 32'(strobe_cyc[1] - strobe_cyc[0]), 32'd13);
        end
        chk("alu_no_err", 32'(err_cnt), 32'd0);
        chk("alu_sched_idle", 32'(sched_busy), 32'd0);

        // Busy never rises: RF then ALU.
        delay_mode = 2;
        clear_logs();
        cmd_rf = 1; cmd_rf_data = 8'h3C;
        tick();
        run_until_idle(200);
        chk("rf_to_errs", 32'(err_cnt), 32'd1);
        chk("rf_to_delay", 32'(last_err_cyc - strobe_cyc[0]), 32'd32);
        chk("rf_to_strobes", 32'(strobe_log.size()), 32'd1);
        clear_logs();
        cmd_alu = 1; cmd_alu_data = 16'hC3A7;
        tick();
        run_until_idle(200);
        chk("alu_to_errs", 32'(err_cnt), 32'd1);
        chk("alu_to_strobes", 32'(strobe_log.size()), 32'd1);
        if (strobe_log.size() == 1) chk("alu_to_byte", 32'(strobe_log[0]), 32'h00A7);

        // Transmitter busy while idle: grant waits for it to fall.
        delay_mode = 1;
        clear_logs();
        for (int j = 1; j <= 6; j++) busy_sched[cyc + j] = 1'b1;
        cmd_rf = 1; cmd_rf_data = 8'h99;
        tick();
        run_until_idle(200);
        chk("idle_busy_ack", 32'(last_ack_cyc - cmd_cyc), 32'd7);
        chk("idle_busy_acks", 32'(ack_log.size()), 32'd1);

        // Reset in WAIT_LO between the two ALU bytes.
        clear_logs();
        cmd_alu = 1; cmd_alu_data = 16'h5AA5;
        repeat (6) tick();
        chk("mid_first_only", 32'(strobe_log.size()), 32'd1);
        do_reset();
        clear_logs();
        repeat (30) tick();
        chk("mid_no_strobe", 32'(strobe_log.size()), 32'd0);
        cmd_rf = 1; cmd_rf_data = 8'h77;
        tick();
        run_until_idle(200);
        chk("mid_rf_acks", 32'(ack_log.size()), 32'd1);
        if (strobe_log.size() == 1) chk("mid_rf_byte", 32'(strobe_log[0]), 32'h0077);
        else chk("mid_rf_strobes", 32'(strobe_log.size()), 32'd1);

        // Randomized traffic, transmitter timing and idle busy noise.
        delay_mode = 0;
        req_rand = 1;
        noise_en = 1;
        repeat (3000) tick();
        req_rand = 0;
        noise_en = 0;
        cmd_drop = 1;
        run_until_idle(400);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
